miner_job_sequencer: RTL

Synthesizable job sequencer that feeds the nonce-search miner a programmable list of block headers and difficulty targets, one job after another. It holds the miner idle while each header settles, releases it, then collects the nonce or declares a timeout. Each outcome is reported on a result port. It sits between the configuration/host side and the miner core, and replaces hand-driven header/reset sequencing. It generalises that sequencing in header width, job count and timeout.

---
 rtl/miner_seq_pkg.sv | 31 +++
 rtl/miner_job_table.sv | 55 +++++
 rtl/miner_job_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/miner_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : miner_seq_pkg
//  Purpose  : Shared definitions for the miner job sequencer: sequencer state
//             encodings, ARM hold length, nonce/target widths and a helper
//             for index widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package miner_seq_pkg;

    // Cycles the miner is held idle while a freshly loaded header settles.
    localparam int ARM_CYCLES = 2;
    localparam int NONCE_W    = 32;
    localparam int TARGET_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miner_job_table.sv
`default_nettype none
// ============================================================================
//  Module   : miner_job_table
//  Purpose  : Job table register file. One synchronous write port, one
//             asynchronous read port. Out-of-range addresses write nothing
//             and read as zero.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             i_we, i_wr_addr,
//             i_wr_data         - write port
//             i_rd_addr         - read address
//             o_rd_data         - combinational read data
//  Revision : 1.0 - initial release
// ============================================================================
module miner_job_table #(
    parameter int NUM_JOBS = 4,
    parameter int AW       = 2,
    parameter int DW       = 104
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [NUM_JOBS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_JOBS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            // Address decode per entry so indices >= NUM_JOBS match nothing.
            for (int i = 0; i < NUM_JOBS; i++) begin
                if (i_wr_addr == AW'(i)) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_JOBS; i++) begin
            if (i_rd_addr == AW'(i)) begin
                o_rd_data = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/miner_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : miner_job_sequencer
//  Purpose  : Feeds the nonce-search miner a programmable list of headers and
//             targets. Each job is loaded, held for ARM_CYCLES with the miner
//             idle, released, then closed by a found nonce or a timeout and
//             reported on the result port.
//  Ports    : clk, reset                      - clock, async active-high reset
//             cfg_we/cfg_addr/cfg_header/
//             cfg_target                      - job table write (idle only)
//             num_jobs, start, abort          - sequence control
//             data_in, target, miner_en       - registered drive to the miner
//             finished, nonce_out             - miner completion
//             result_valid/job/nonce/timeout  - per-job result
//             found_count, busy, done         - sequence status
//  Revision : 1.0 - initial release
// ============================================================================
module miner_job_sequencer
    import miner_seq_pkg::*;
#(
    parameter  int BYTE      = 8,
    parameter  int HDR_BYTES = 12,
    parameter  int NUM_JOBS  = 4,
    parameter  int TIMEOUT   = 65536,
    localparam int HW        = BYTE * HDR_BYTES,
    localparam int JW        = idx_width(NUM_JOBS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [JW-1:0]       cfg_addr,
    input  logic [HW-1:0]       cfg_header,
    input  logic [TARGET_W-1:0] cfg_target,
    input  logic [JW:0]         num_jobs,
    input  logic                start,
    input  logic                abort,
    output logic [HW-1:0]       data_in,
    output logic [TARGET_W-1:0] target,
    output logic                miner_en,
    input  logic                finished,
    input  logic [NONCE_W-1:0]  nonce_out,
    output logic                result_valid,
    output logic [JW-1:0]       result_job,
    output logic [NONCE_W-1:0]  result_nonce,
    output logic                result_timeout,
    output logic [JW:0]         found_count,
    output logic                busy,
    output logic                done
);

    localparam int              c_cw       = $clog2(TIMEOUT);
    localparam int              c_ew       = HW + TARGET_W;
    localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TIMEOUT - 1);
    localparam logic [1:0]      c_arm_last = 2'(ARM_CYCLES - 1);
    localparam logic [JW:0]     c_max_jobs = (JW+1)'(NUM_JOBS);
    localparam logic [JW:0]     c_one_job  = (JW+1)'(1);

    seq_state_t      r_state;
    logic [JW-1:0]   r_job_idx;
    logic [JW:0]     r_count;
    logic [c_cw-1:0] r_tmo_cnt;
    logic [1:0]      r_arm_cnt;

    logic            w_tbl_we;
    logic [JW-1:0]   w_rd_addr;
    logic [c_ew-1:0] w_rd_data;
    logic [JW:0]     w_count_clamped;
    logic            w_last_job;

    // Table is frozen while a sequence runs so in-flight jobs stay coherent.
    assign w_tbl_we = cfg_we && (r_state == ST_IDLE);

    // Entry 0 is the one loaded on start; in REPORT the next entry is
    // prefetched so it lands on data_in at the REPORT->ARM edge.
    assign w_rd_addr = (r_state == ST_REPORT) ? (r_job_idx + 1'b1) : '0;

    always_comb begin
        w_count_clamped = num_jobs;
        if (num_jobs == '0) begin
            w_count_clamped = c_one_job;
        end else if (num_jobs > c_max_jobs) begin
            w_count_clamped = c_max_jobs;
        end
    end

    assign w_last_job = ({1'b0, r_job_idx} == (r_count - 1'b1));

    miner_job_table #(
        .NUM_JOBS (NUM_JOBS),
        .AW       (JW),
        .DW       (c_ew)
    ) u_job_table (
        .clk       (clk),
        .rst       (reset),
        .i_we      (w_tbl_we),
        .i_wr_addr (cfg_addr),
        .i_wr_data ({cfg_header, cfg_target}),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_job_idx      <= '0;
            r_count        <= '0;
            r_tmo_cnt      <= '0;
            r_arm_cnt      <= '0;
            data_in        <= '0;
            target         <= '0;
            miner_en       <= 1'b0;
            result_valid   <= 1'b0;
            result_job     <= '0;
            result_nonce   <= '0;
            result_timeout <= 1'b0;
            found_count    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            // Strobes default low; result_* data fields hold between results.
            result_valid <= 1'b0;
            done         <= 1'b0;

            if (abort && (r_state != ST_IDLE)) begin
                // Silent stop: no result, no done, found_count preserved.
                r_state  <= ST_IDLE;
                miner_en <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_count               <= w_count_clamped;
                            r_job_idx             <= '0;
                            found_count           <= '0;
                            {data_in, target}     <= w_rd_data;
                            r_arm_cnt             <= '0;
                            busy                  <= 1'b1;
                            r_state               <= ST_ARM;
                        end
                    end

                    ST_ARM: begin
                        if (r_arm_cnt == c_arm_last) begin
                            miner_en  <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_state   <= ST_RUN;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 1'b1;
                        end
                    end

                    ST_RUN: begin
                        // finished is tested first so a nonce arriving on the
                        // final counted cycle is still reported as found.
                        if (finished) begin
                            result_nonce   <= nonce_out;
                            result_timeout <= 1'b0;
                            result_job     <= r_job_idx;
                            result_valid   <= 1'b1;
                            found_count    <= found_count + 1'b1;
                            miner_en       <= 1'b0;
                            r_state        <= ST_REPORT;
                        end else if (r_tmo_cnt == c_tmo_last) begin
                            result_nonce   <= '0;
                            result_timeout <= 1'b1;
                            result_job     <= r_job_idx;
                            result_valid   <= 1'b1;
                            miner_en       <= 1'b0;
                            r_state        <= ST_REPORT;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end

                    ST_REPORT: begin
                        if (w_last_job) begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_job_idx         <= r_job_idx + 1'b1;
                            {data_in, target} <= w_rd_data;
                            r_arm_cnt         <= '0;
                            r_state           <= ST_ARM;
                        end
                    end

                    ST_DONE: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        miner_en <= 1'b0;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
